// File: rtl/traffic_light_monitor_pkg.sv
// Shared encodings and helpers for the traffic light monitor.
// Pure definitions: no state, no latency, no flow control.
package traffic_light_monitor_pkg;

    typedef enum logic [1:0] {
        MODE_DARK   = 2'd0,
        MODE_TEST   = 2'd1,
        MODE_FLASH  = 2'd2,
        MODE_NORMAL = 2'd3
    } mode_e;

    typedef enum logic [2:0] {
        FC_NONE     = 3'd0,
        FC_CONFLICT = 3'd1,
        FC_MULTI    = 3'd2,
        FC_SEQ      = 3'd3,
        FC_COUNT    = 3'd4,
        FC_TIMEOUT  = 3'd5
    } fault_code_e;

    typedef enum logic [1:0] {
        LS_R   = 2'd0,
        LS_Y   = 2'd1,
        LS_G   = 2'd2,
        LS_BAD = 2'd3
    } lamp_state_e;

    typedef struct packed {
        logic r;
        logic y;
        logic g;
    } lamps_t;

    localparam logic [7:0] SAT8 = 8'hff;

    // A direction is in a defined state only when exactly one lamp is lit.
    function automatic lamp_state_e classify_lamps(input lamps_t l);
        case ({l.r, l.y, l.g})
            3'b100:  return LS_R;
            3'b010:  return LS_Y;
            3'b001:  return LS_G;
            default: return LS_BAD;
        endcase
    endfunction

    function automatic logic legal_step(input lamp_state_e from_s, input lamp_state_e to_s);
        return (from_s == LS_G && to_s == LS_Y) ||
               (from_s == LS_Y && to_s == LS_R) ||
               (from_s == LS_R && to_s == LS_G);
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == SAT8) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/traffic_light_monitor_lamp_seq_checker.sv
// Per-direction lamp classification, run-length tracking, SEQ and TIMEOUT detection.
// Detect outputs are combinational on the current sample; history is registered each edge.
module lamp_seq_checker
    import traffic_light_monitor_pkg::*;
#(
    parameter int GREEN_MAX  = 60,
    parameter int YELLOW_MAX = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  lamps_t      lamps_i,
    input  logic        normal_i,
    input  logic        track_i,
    output lamp_state_e state_o,
    output logic        seq_o,
    output logic        timeout_o
);

    lamp_state_e state_d;
    lamp_state_e state_q;
    logic [7:0]  run_d;
    logic [7:0]  run_q;
    logic        to_seen_d;
    logic        to_seen_q;
    logic        over_limit;

    assign state_d = classify_lamps(lamps_i);
    assign state_o = state_d;

    always_comb begin
        run_d      = 8'd0;
        to_seen_d  = 1'b0;
        seq_o      = 1'b0;
        over_limit = 1'b0;
        timeout_o  = 1'b0;
        if (normal_i) begin
            if (track_i && state_d == state_q) begin
                run_d     = sat_inc8(run_q);
                to_seen_d = to_seen_q;
            end else begin
                run_d = 8'd1;
            end
            seq_o      = track_i && (state_d != state_q) && !legal_step(state_q, state_d);
            over_limit = (state_d == LS_G && int'(run_d) > GREEN_MAX) ||
                         (state_d == LS_Y && int'(run_d) > YELLOW_MAX);
            // Report the overrun once; the flag holds until the run ends.
            timeout_o  = over_limit && !to_seen_d;
            to_seen_d  = to_seen_d | over_limit;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= LS_BAD;
            run_q     <= 8'd0;
            to_seen_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            run_q     <= run_d;
            to_seen_q <= to_seen_d;
        end
    end

endmodule

// File: rtl/traffic_light_monitor.sv
// Safety monitor for a two-direction traffic light controller; sticky fault with priority code.
// Faults seen at edge k are registered at edge k; no backpressure, samples every cycle.
module traffic_light_monitor
    import traffic_light_monitor_pkg::*;
#(
    parameter int GREEN_MAX  = 60,
    parameter int YELLOW_MAX = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       hr,
    input  logic       hy,
    input  logic       hg,
    input  logic       vr,
    input  logic       vy,
    input  logic       vg,
    input  logic [7:0] count,
    input  logic       fault_ack,
    output logic       fault,
    output logic [2:0] fault_code,
    output logic       force_flicker,
    output logic [1:0] mode,
    output logic [7:0] err_cnt
);

    lamps_t      h_lamps;
    lamps_t      v_lamps;
    logic [5:0]  lamps_cur;
    logic [5:0]  prev_lamps_q;
    logic [7:0]  prev_count_q;
    mode_e       mode_d;
    mode_e       mode_q;
    logic        normal;
    logic        track;
    lamp_state_e h_state;
    lamp_state_e v_state;
    logic        h_seq;
    logic        v_seq;
    logic        h_to;
    logic        v_to;
    logic        conflict;
    logic        multi;
    logic        count_err;
    fault_code_e new_code;
    logic        fault_d;
    logic        fault_q;
    fault_code_e fault_code_d;
    fault_code_e fault_code_q;
    logic [7:0]  err_cnt_d;
    logic [7:0]  err_cnt_q;

    assign h_lamps   = {hr, hy, hg};
    assign v_lamps   = {vr, vy, vg};
    assign lamps_cur = {h_lamps, v_lamps};

    // All-off keeps FLASH alive so the dark half of a blink is not seen as DARK.
    always_comb begin
        case (lamps_cur)
            6'b000000: mode_d = (mode_q == MODE_FLASH) ? MODE_FLASH : MODE_DARK;
            6'b111111: mode_d = MODE_TEST;
            6'b010010: mode_d = MODE_FLASH;
            default:   mode_d = MODE_NORMAL;
        endcase
    end

    assign normal = (mode_d == MODE_NORMAL);
    assign track  = normal && (mode_q == MODE_NORMAL);

    lamp_seq_checker #(
        .GREEN_MAX  (GREEN_MAX),
        .YELLOW_MAX (YELLOW_MAX)
    ) u_h_chk (
        .clk       (clk),
        .rst       (rst),
        .lamps_i   (h_lamps),
        .normal_i  (normal),
        .track_i   (track),
        .state_o   (h_state),
        .seq_o     (h_seq),
        .timeout_o (h_to)
    );

    lamp_seq_checker #(
        .GREEN_MAX  (GREEN_MAX),
        .YELLOW_MAX (YELLOW_MAX)
    ) u_v_chk (
        .clk       (clk),
        .rst       (rst),
        .lamps_i   (v_lamps),
        .normal_i  (normal),
        .track_i   (track),
        .state_o   (v_state),
        .seq_o     (v_seq),
        .timeout_o (v_to)
    );

    assign conflict  = normal && (hg | hy) && (vg | vy);
    assign multi     = normal && (h_state == LS_BAD || v_state == LS_BAD);
    // A held lamp state must see the countdown step by exactly one, never below zero.
    assign count_err = track && (lamps_cur == prev_lamps_q) &&
                       (prev_count_q == 8'd0 || count != prev_count_q - 8'd1);

    always_comb begin
        if (conflict)          new_code = FC_CONFLICT;
        else if (multi)        new_code = FC_MULTI;
        else if (h_seq | v_seq) new_code = FC_SEQ;
        else if (count_err)    new_code = FC_COUNT;
        else if (h_to | v_to)  new_code = FC_TIMEOUT;
        else                   new_code = FC_NONE;
    end

    always_comb begin
        fault_d      = fault_q;
        fault_code_d = fault_code_q;
        err_cnt_d    = err_cnt_q;
        if (new_code != FC_NONE) begin
            fault_d   = 1'b1;
            err_cnt_d = sat_inc8(err_cnt_q);
            if (!fault_q || fault_ack) begin
                fault_code_d = new_code;
            end
        end else if (fault_ack) begin
            fault_d      = 1'b0;
            fault_code_d = FC_NONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_lamps_q <= 6'b000000;
            prev_count_q <= 8'd0;
            mode_q       <= MODE_DARK;
            fault_q      <= 1'b0;
            fault_code_q <= FC_NONE;
            err_cnt_q    <= 8'd0;
        end else begin
            prev_lamps_q <= lamps_cur;
            prev_count_q <= count;
            mode_q       <= mode_d;
            fault_q      <= fault_d;
            fault_code_q <= fault_code_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    assign fault         = fault_q;
    assign force_flicker = fault_q;
    assign fault_code    = fault_code_q;
    assign mode          = mode_q;
    assign err_cnt       = err_cnt_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Randomised and directed bench for traffic_light_monitor against a sample-history reference model.
module tb_traffic_light_monitor;

    localparam int GMAX = 60;
    localparam int YMAX = 5;

    // lamp vector layout: {hr, hy, hg, vr, vy, vg}
    localparam bit [5:0] HG_VR   = 6'b001100;
    localparam bit [5:0] HY_VR   = 6'b010100;
    localparam bit [5:0] HR_VG   = 6'b100001;
    localparam bit [5:0] HR_VY   = 6'b100010;
    localparam bit [5:0] ALL_ON  = 6'b111111;
    localparam bit [5:0] ALL_OFF = 6'b000000;
    localparam bit [5:0] FLASH_Y = 6'b010010;
    localparam bit [5:0] BOTH_G  = 6'b001001;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       hr = 1'b0, hy = 1'b0, hg = 1'b0, vr = 1'b0, vy = 1'b0, vg = 1'b0;
    logic [7:0] count = 8'd0;
    logic       fault_ack = 1'b0;

    logic       fault, force_flicker;
    logic [2:0] fault_code;
    logic [1:0] mode;
    logic [7:0] err_cnt;

    logic       t_fault, t_force_flicker;
    logic [2:0] t_fault_code;
    logic [1:0] t_mode;
    logic [7:0] t_err_cnt;

    traffic_light_monitor dut (
        .clk(clk), .rst(rst),
        .hr(hr), .hy(hy), .hg(hg), .vr(vr), .vy(vy), .vg(vg),
        .count(count), .fault_ack(fault_ack),
        .fault(fault), .fault_code(fault_code), .force_flicker(force_flicker),
        .mode(mode), .err_cnt(err_cnt)
    );

    traffic_light_monitor #(.GREEN_MAX(4), .YELLOW_MAX(5)) dut_t (
        .clk(clk), .rst(rst),
        .hr(hr), .hy(hy), .hg(hg), .vr(vr), .vy(vy), .vg(vg),
        .count(count), .fault_ack(fault_ack),
        .fault(t_fault), .fault_code(t_fault_code), .force_flicker(t_force_flicker),
        .mode(t_mode), .err_cnt(t_err_cnt)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0d, expected %0d", tag, $time, got, exp);
        end
    endtask

    // Reference model: keeps the NORMAL samples of the current segment and derives runs by scanning back.
    bit [5:0] m_prev_lamps;
    int       m_prev_cnt;
    int       m_mode;
    bit [5:0] seg[$];
    bit       m_fault;
    int       m_code;
    int       m_err;

    function automatic byte dir_state(input bit [2:0] ryg);
        case (ryg)
            3'b100:  return "R";
            3'b010:  return "Y";
            3'b001:  return "G";
            default: return "X";
        endcase
    endfunction

    function automatic bit bad_step(input byte a, input byte b);
        if (a == b) return 1'b0;
        return !((a == "G" && b == "Y") || (a == "Y" && b == "R") || (a == "R" && b == "G"));
    endfunction

    function automatic bit timed_out(input bit hdir);
        byte s;
        int  run;
        if (seg.size() == 0) return 1'b0;
        s   = hdir ? dir_state(seg[seg.size()-1][5:3]) : dir_state(seg[seg.size()-1][2:0]);
        run = 0;
        for (int i = seg.size() - 1; i >= 0; i--) begin
            if ((hdir ? dir_state(seg[i][5:3]) : dir_state(seg[i][2:0])) != s) break;
            run++;
        end
        return (s == "G" && run == GMAX + 1) || (s == "Y" && run == YMAX + 1);
    endfunction

    task automatic model_reset();
        m_prev_lamps = 6'b0;
        m_prev_cnt   = 0;
        m_mode       = 0;
        seg.delete();
        m_fault      = 1'b0;
        m_code       = 0;
        m_err        = 0;
    endtask

    task automatic model_step(input bit [5:0] l, input int c, input bit ack);
        int  md;
        int  code;
        bit  nrm, chk, cf, mu, sq, ce, to;
        if (l == 6'b0)         md = (m_mode == 2) ? 2 : 0;
        else if (l == ALL_ON)  md = 1;
        else if (l == FLASH_Y) md = 2;
        else                   md = 3;
        nrm = (md == 3);
        chk = nrm && (m_mode == 3);
        cf  = nrm && (l[4] || l[3]) && (l[1] || l[0]);
        mu  = nrm && (dir_state(l[5:3]) == "X" || dir_state(l[2:0]) == "X");
        sq  = chk && (bad_step(dir_state(m_prev_lamps[5:3]), dir_state(l[5:3])) ||
                      bad_step(dir_state(m_prev_lamps[2:0]), dir_state(l[2:0])));
        ce  = chk && (l == m_prev_lamps) && (m_prev_cnt == 0 || c != m_prev_cnt - 1);
        if (!chk) seg.delete();
        if (nrm) seg.push_back(l);
        if (seg.size() > 300) void'(seg.pop_front());
        to  = timed_out(1'b1) || timed_out(1'b0);
        code = cf ? 1 : mu ? 2 : sq ? 3 : ce ? 4 : to ? 5 : 0;
        if (code != 0) begin
            if (!m_fault || ack) m_code = code;
            m_fault = 1'b1;
            if (m_err < 255) m_err++;
        end else if (ack) begin
            m_fault = 1'b0;
            m_code  = 0;
        end
        m_prev_lamps = l;
        m_prev_cnt   = c;
        m_mode       = md;
    endtask

    task automatic tick(input bit [5:0] l, input int c, input bit ack, input bit r);
        {hr, hy, hg, vr, vy, vg} = l;
        count     = c[7:0];
        fault_ack = ack;
        rst       = r;
        @(posedge clk);
        #1;
        if (r) model_reset();
        else   model_step(l, c, ack);
        check("fault", int'(fault), int'(m_fault));
        check("fault_code", int'(fault_code), m_code);
        check("force_flicker", int'(force_flicker), int'(m_fault));
        check("mode", int'(mode), m_mode);
        check("err_cnt", int'(err_cnt), m_err);
    endtask

    bit [5:0] phase_lamps[4] = '{HG_VR, HY_VR, HR_VG, HR_VY};

    initial begin
        int       ph;
        int       cnt;
        int       r;
        bit       ack;
        bit       rr;
        bit [5:0] l;

        model_reset();
        tick(ALL_OFF, 0, 0, 1);
        tick(ALL_OFF, 0, 0, 1);
        check("rst_fault", int'(fault), 0);
        check("rst_code", int'(fault_code), 0);
        check("rst_mode", int'(mode), 0);
        check("rst_err", int'(err_cnt), 0);

        // Legal full cycle: no fault throughout.
        for (int k = 10; k >= 1; k--) tick(HG_VR, k, 0, 0);
        for (int k = 3; k >= 1; k--)  tick(HY_VR, k, 0, 0);
        for (int k = 10; k >= 1; k--) tick(HR_VG, k, 0, 0);
        for (int k = 3; k >= 1; k--)  tick(HR_VY, k, 0, 0);
        for (int k = 10; k >= 1; k--) tick(HG_VR, k, 0, 0);
        check("legal_fault", int'(fault), 0);
        check("legal_err", int'(err_cnt), 0);

        // Both greens with V red still lit: CONFLICT outranks MULTI.
        tick(6'b001101, 9, 0, 0);
        check("conflict_fault", int'(fault), 1);
        check("conflict_code", int'(fault_code), 1);
        check("conflict_flicker", int'(force_flicker), 1);
        check("conflict_err", int'(err_cnt), 1);

        // Illegal G->R, then ack, then stalled countdown.
        tick(ALL_OFF, 0, 0, 1);
        tick(HG_VR, 5, 0, 0);
        tick(HG_VR, 4, 0, 0);
        tick(HG_VR, 3, 0, 0);
        tick(HR_VG, 9, 0, 0);
        check("seq_code", int'(fault_code), 3);
        tick(HR_VG, 8, 1, 0);
        check("ack_fault", int'(fault), 0);
        check("ack_code", int'(fault_code), 0);
        tick(HR_VG, 7, 0, 0);
        tick(HR_VG, 7, 0, 0);
        check("count_code", int'(fault_code), 4);
        check("count_err", int'(err_cnt), 2);

        // Green overrun on the GREEN_MAX=4 instance, reported once per run.
        tick(ALL_OFF, 0, 0, 1);
        for (int k = 0; k < 4; k++) tick(HG_VR, 9 - k, 0, 0);
        check("to_before_err", int'(t_err_cnt), 0);
        tick(HG_VR, 5, 0, 0);
        check("to_code", int'(t_fault_code), 5);
        check("to_err", int'(t_err_cnt), 1);
        for (int k = 4; k >= 2; k--) tick(HG_VR, k, 0, 0);
        check("to_once_err", int'(t_err_cnt), 1);

        // TEST -> DARK -> flashing -> NORMAL.
        tick(ALL_OFF, 0, 0, 1);
        tick(ALL_ON, 0, 0, 0);
        check("mode_test", int'(mode), 1);
        tick(ALL_OFF, 0, 0, 0);
        check("mode_dark", int'(mode), 0);
        tick(FLASH_Y, 0, 0, 0);
        check("mode_flash_on", int'(mode), 2);
        tick(ALL_OFF, 0, 0, 0);
        check("mode_flash_off", int'(mode), 2);
        tick(FLASH_Y, 0, 0, 0);
        tick(ALL_OFF, 0, 0, 0);
        tick(HG_VR, 9, 0, 0);
        check("mode_normal", int'(mode), 3);
        check("modes_fault", int'(fault), 0);

        // Saturation of the error counter, then reset mid-run.
        for (int k = 0; k < 300; k++) tick(BOTH_G, 0, 0, 0);
        check("err_sat", int'(err_cnt), 255);
        tick(HG_VR, 5, 0, 1);
        check("midrst_fault", int'(fault), 0);
        check("midrst_code", int'(fault_code), 0);
        check("midrst_flicker", int'(force_flicker), 0);
        check("midrst_mode", int'(mode), 0);
        check("midrst_err", int'(err_cnt), 0);

        // Random traffic: mostly plausible phases with injected glitches, acks and resets.
        ph  = 0;
        cnt = 10;
        for (int i = 0; i < 3000; i++) begin
            r   = $urandom_range(0, 99);
            ack = ($urandom_range(0, 9) == 0);
            rr  = ($urandom_range(0, 199) == 0);
            if (r < 75) begin
                if (cnt <= 1 || $urandom_range(0, 29) == 0) begin
                    ph  = (ph + (($urandom_range(0, 19) == 0) ? 2 : 1)) % 4;
                    cnt = $urandom_range(1, 75);
                end else if ($urandom_range(0, 24) == 0) begin
                    cnt = $urandom_range(0, 255);
                end else begin
                    cnt = cnt - 1;
                end
                l = phase_lamps[ph];
            end else if (r < 83) begin
                l   = 6'($urandom_range(0, 63));
                cnt = $urandom_range(0, 255);
            end else if (r < 91) begin
                l = ($urandom_range(0, 1) == 1) ? FLASH_Y : ALL_OFF;
            end else if (r < 95) begin
                l = ALL_ON;
            end else begin
                l = phase_lamps[ph];
            end
            tick(l, cnt, ack, rr);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
